// File: rtl/priority_irq_controller.sv
// Eight-source priority interrupt controller: synchronized edge detection, pending flags and a
// non-preemptive present/acknowledge handshake. Define IRQ_MASK_EN to add a writable source mask.
module priority_irq_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       ack,
`ifdef IRQ_MASK_EN
    input  logic       mask_wr,
    input  logic [7:0] mask_data,
`endif
    output logic       valid,
    output logic [2:0] code,
    output logic [7:0] pending
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] synced;
    logic [7:0] prev_q;
    logic [7:0] rise;
    logic [7:0] mask_q;
    logic [7:0] eligible;
    logic [7:0] clear_vec;
    logic [7:0] pending_q;
    logic [2:0] code_q;
    logic [2:0] top_idx;
    logic       any_eligible;

    // Multi-stage synchronizer per request line, then a previous-sample flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= synced;
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~prev_q;

`ifdef IRQ_MASK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else if (mask_wr) begin
            mask_q <= mask_data;
        end
    end
`else
    assign mask_q = '0;
`endif

    assign eligible     = pending_q & ~mask_q;
    assign any_eligible = |eligible;

    // Ascending scan so the highest set index is the one left standing.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) begin
                top_idx = 3'(i);
            end
        end
    end

    always_comb begin
        clear_vec = '0;
        if (state_q == PRESENT && ack) begin
            clear_vec[code_q] = 1'b1;
        end
    end

    // A fresh edge is OR-ed in after the clear, so a same-cycle re-arrival survives its own ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clear_vec) | rise;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_eligible) state_d = PRESENT;
            PRESENT: if (ack)          state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // The code is captured only on entry to PRESENT and otherwise holds its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= '0;
        end else if (state_q == IDLE && any_eligible) begin
            code_q <= top_idx;
        end
    end

    always_comb begin
        valid = (state_q == PRESENT);
    end

    assign code    = code_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_priority_irq_controller.sv
// Self-checking bench for priority_irq_controller: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model. IRQ_MASK_EN adds mask coverage.
module tb_priority_irq_controller;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       ack;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pending;
`ifdef IRQ_MASK_EN
    logic       mask_wr;
    logic [7:0] mask_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Model state: presented flag/code, pending set, mask, and the last S+1 request samples.
    bit         m_valid;
    logic [2:0] m_code;
    logic [7:0] m_pending;
    logic [7:0] m_mask;
    logic [7:0] m_rise;
    logic [7:0] m_elig;
    logic [7:0] hist[$];

    priority_irq_controller #(.SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ack      (ack),
`ifdef IRQ_MASK_EN
        .mask_wr  (mask_wr),
        .mask_data(mask_data),
`endif
        .valid    (valid),
        .code     (code),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronized view of req as seen 'back' edges ago, read straight from the sample history.
    function automatic logic [7:0] synced_at(input int back);
        int idx;
        idx = hist.size() - S - back;
        if (idx >= 0) return hist[idx];
        return 8'h00;
    endfunction

    function automatic logic [2:0] highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   = 1'b0;
            m_code    = 3'd0;
            m_pending = 8'h00;
            m_mask    = 8'h00;
            hist.delete();
        end else begin
            m_rise = synced_at(0) & ~synced_at(1);
            m_elig = m_pending & ~m_mask;
            if (m_valid) begin
                if (ack) begin
                    m_pending[m_code] = 1'b0;
                    m_valid = 1'b0;
                end
            end else if (m_elig != 8'h00) begin
                m_valid = 1'b1;
                m_code  = highest(m_elig);
            end
            m_pending = m_pending | m_rise;
`ifdef IRQ_MASK_EN
            if (mask_wr) m_mask = mask_data;
`endif
            hist.push_back(req);
            if (hist.size() > S + 1) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_output("model_valid", {31'd0, valid}, {31'd0, m_valid});
            check_output("model_code", {29'd0, code}, {29'd0, m_code});
            check_output("model_pending", {24'd0, pending}, {24'd0, m_pending});
        end
    end

    task automatic apply_stimulus(input logic [7:0] r, input logic a);
        req = r;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        ack = 1'b0;
`ifdef IRQ_MASK_EN
        mask_wr   = 1'b0;
        mask_data = 8'h00;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        do_reset();
        check_en = 1'b1;
        check_output("reset_valid", {31'd0, valid}, 32'd0);
        check_output("reset_code", {29'd0, code}, 32'd0);
        check_output("reset_pending", {24'd0, pending}, 32'd0);

        // Single source: pending after edge 3, presented after edge 4.
        apply_stimulus(8'h04, 1'b0);
        apply_stimulus(8'h04, 1'b0);
        check_output("single_pending_e2", {24'd0, pending}, 32'h00);
        apply_stimulus(8'h04, 1'b0);
        check_output("single_pending_e3", {24'd0, pending}, 32'h04);
        check_output("single_valid_e3", {31'd0, valid}, 32'd0);
        apply_stimulus(8'h04, 1'b0);
        check_output("single_valid_e4", {31'd0, valid}, 32'd1);
        check_output("single_code_e4", {29'd0, code}, 32'd2);
        apply_stimulus(8'h04, 1'b1);
        check_output("single_pending_ack", {24'd0, pending}, 32'h00);
        check_output("single_valid_ack", {31'd0, valid}, 32'd0);
        check_output("single_code_hold", {29'd0, code}, 32'd2);

        // Simultaneous sources 7 and 0.
        do_reset();
        repeat (4) apply_stimulus(8'h81, 1'b0);
        check_output("prio_code7", {29'd0, code}, 32'd7);
        check_output("prio_pending", {24'd0, pending}, 32'h81);
        apply_stimulus(8'h81, 1'b1);
        check_output("prio_idle_gap", {31'd0, valid}, 32'd0);
        check_output("prio_pending_after7", {24'd0, pending}, 32'h01);
        apply_stimulus(8'h81, 1'b0);
        check_output("prio_valid0", {31'd0, valid}, 32'd1);
        check_output("prio_code0", {29'd0, code}, 32'd0);
        apply_stimulus(8'h81, 1'b1);
        check_output("prio_pending_end", {24'd0, pending}, 32'h00);

        // Higher-priority arrival while presenting must not preempt.
        do_reset();
        repeat (4) apply_stimulus(8'h02, 1'b0);
        check_output("nopre_code1", {29'd0, code}, 32'd1);
        repeat (5) apply_stimulus(8'h42, 1'b0);
        check_output("nopre_code_stays", {29'd0, code}, 32'd1);
        check_output("nopre_pending", {24'd0, pending}, 32'h42);
        apply_stimulus(8'h42, 1'b1);
        check_output("nopre_valid_gap", {31'd0, valid}, 32'd0);
        apply_stimulus(8'h42, 1'b0);
        check_output("nopre_code6", {29'd0, code}, 32'd6);
        check_output("nopre_valid6", {31'd0, valid}, 32'd1);
        apply_stimulus(8'h42, 1'b1);

        // Re-edge on source 3 lands on the same edge that acks code 3.
        do_reset();
        repeat (4) apply_stimulus(8'h08, 1'b0);
        check_output("setwin_code3", {29'd0, code}, 32'd3);
        repeat (S) apply_stimulus(8'h00, 1'b0);
        repeat (S) apply_stimulus(8'h08, 1'b0);
        apply_stimulus(8'h08, 1'b1);
        check_output("setwin_pending", {24'd0, pending}, 32'h08);
        check_output("setwin_valid_gap", {31'd0, valid}, 32'd0);
        apply_stimulus(8'h08, 1'b0);
        check_output("setwin_again", {31'd0, valid}, 32'd1);
        check_output("setwin_code_again", {29'd0, code}, 32'd3);

`ifdef IRQ_MASK_EN
        do_reset();
        mask_wr = 1'b1;
        mask_data = 8'h80;
        apply_stimulus(8'h00, 1'b0);
        mask_wr = 1'b0;
        repeat (4) apply_stimulus(8'h90, 1'b0);
        check_output("mask_code4", {29'd0, code}, 32'd4);
        check_output("mask_pending", {24'd0, pending}, 32'h90);
        apply_stimulus(8'h90, 1'b1);
        apply_stimulus(8'h90, 1'b0);
        check_output("mask_blocked", {31'd0, valid}, 32'd0);
        mask_wr = 1'b1;
        mask_data = 8'h00;
        apply_stimulus(8'h90, 1'b0);
        mask_wr = 1'b0;
        check_output("mask_write_edge", {31'd0, valid}, 32'd0);
        apply_stimulus(8'h90, 1'b0);
        check_output("mask_code7", {29'd0, code}, 32'd7);
        check_output("mask_valid7", {31'd0, valid}, 32'd1);
        mask_wr = 1'b1;
        mask_data = 8'h80;
        apply_stimulus(8'h90, 1'b0);
        mask_wr = 1'b0;
        check_output("mask_no_retract", {29'd0, code}, 32'd7);
        check_output("mask_no_retract_v", {31'd0, valid}, 32'd1);
`endif

        // Asynchronous reset while presenting, then a held request is seen as a fresh edge.
        do_reset();
        repeat (4) apply_stimulus(8'h30, 1'b0);
        check_output("rstmid_valid_pre", {31'd0, valid}, 32'd1);
        check_output("rstmid_code_pre", {29'd0, code}, 32'd5);
        check_output("rstmid_pending_pre", {24'd0, pending}, 32'h30);
        #2;
        rst = 1'b1;
        #1;
        check_output("rstmid_valid", {31'd0, valid}, 32'd0);
        check_output("rstmid_pending", {24'd0, pending}, 32'h00);
        check_output("rstmid_code", {29'd0, code}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) apply_stimulus(8'h30, 1'b0);
        check_output("rstmid_redetect", {24'd0, pending}, 32'h30);
        apply_stimulus(8'h30, 1'b0);
        check_output("rstmid_code5", {29'd0, code}, 32'd5);

        // Randomized traffic: sparse toggles on the request lines, random ack.
        do_reset();
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            r = r ^ 8'($urandom & $urandom & $urandom);
`ifdef IRQ_MASK_EN
            mask_wr   = ($urandom_range(0, 15) == 0);
            mask_data = 8'($urandom & $urandom);
`endif
            apply_stimulus(r, $urandom_range(0, 3) == 0);
        end
`ifdef IRQ_MASK_EN
        mask_wr = 1'b0;
`endif
        apply_stimulus(8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
